// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: opcodes, NOP word and FSM encoding.
package instr_fetch_pkg;

  localparam logic [5:0]  HALT_OP   = 6'b111111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:26] == HALT_OP;
  endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats load; with neither asserted it holds.
module if_id_reg
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] pc_plus4_d, pc_plus4_q;
  logic        valid_d, valid_q;

  // Flush turns the slot into a bubble but keeps the last PC for visibility.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  // Register update; pc_plus4 resets to 4 so it always equals pc + 4.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h4;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, fetch FSM and fetch counter feeding the IF/ID register.
//
// state | meaning
// IDLE  | waiting for start, PC parked at RESET_PC, IF/ID holds a bubble
// RUN   | fetching one word per unstalled cycle
// HALT  | HALT word fetched; PC frozen until a redirect arrives
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        instr_out,
  output logic [31:0]        pc_out,
  output logic [31:0]        pc_plus4,
  output logic               valid_out,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_e     state_d, state_q;
  logic [31:0]      pc_d, pc_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             load, flush;
  logic [31:0]      pc_inc;

  assign pc_inc = pc_q + 32'd4;

  // Next-state, PC and counter; redirect outranks stall in RUN and HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = redirect_pc & 32'hFFFF_FFFC;
        end else if (!stall) begin
          load = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          if (is_halt(imem_data)) state_d = ST_HALT;
          else                    pc_d    = pc_inc;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redirect_pc & 32'hFFFF_FFFC;
          state_d = ST_RUN;
        end else if (!stall) begin
          flush = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .flush       (flush),
    .instr_in    (imem_data),
    .pc_in       (pc_q),
    .pc_plus4_in (pc_inc),
    .instr       (instr_out),
    .pc          (pc_out),
    .pc_plus4    (pc_plus4),
    .valid       (valid_out)
  );

  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, start, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data, instr_out, pc_out, pc_plus4;
  logic        valid_out, halted;
  logic [15:0] fetch_count;

  logic        rst2, start2;
  logic [9:0]  imem_addr2;
  logic [31:0] imem_data2, instr_out2, pc_out2, pc_plus4_2;
  logic        valid_out2, halted2;
  logic [2:0]  fetch_count2;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign imem_data  = mem[imem_addr];
  assign imem_data2 = 32'h1234_5678;

  instr_fetch dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .instr_out(instr_out),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .valid_out(valid_out),
    .halted(halted), .fetch_count(fetch_count)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(10), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_addr(imem_addr2), .imem_data(imem_data2), .instr_out(instr_out2),
    .pc_out(pc_out2), .pc_plus4(pc_plus4_2), .valid_out(valid_out2),
    .halted(halted2), .fetch_count(fetch_count2)
  );

  // Behavioural model: mode 0 idle, 1 running, 2 halted.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pcout;
  bit          m_valid;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pcout = 32'h0;
      m_valid = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_instr = 32'h0; m_valid = 0; m_mode = 1;
    end else if (!stall) begin
      if (m_mode == 1) begin
        w = mem[m_pc[11:2]];
        m_instr = w; m_pcout = m_pc; m_valid = 1;
        if (m_cnt < 65535) m_cnt++;
        if (w[31:26] == 6'h3F) m_mode = 2;
        else m_pc = m_pc + 32'd4;
      end else begin
        m_instr = 32'h0; m_valid = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", {22'h0, imem_addr}, {22'h0, m_pc[11:2]});
      chk("instr_out", instr_out, m_instr);
      chk("pc_out", pc_out, m_pcout);
      chk("pc_plus4", pc_plus4, m_pcout + 32'd4);
      chk("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
      chk("halted", {31'h0, halted}, (m_mode == 2) ? 32'h1 : 32'h0);
      chk("fetch_count", {16'h0, fetch_count}, m_cnt[31:0]);
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i * 32'h11;
    mem[8] = 32'hFC00_0000;
    rst = 1; start = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
    rst2 = 1; start2 = 0;
    cyc();
    chk_en = 1;
    chk("rst instr", instr_out, 32'h0);
    chk("rst valid", {31'h0, valid_out}, 32'h0);
    chk("rst pc_plus4", pc_plus4, 32'h4);
    chk("rst2 imem_addr", {22'h0, imem_addr2}, 32'h3FF);

    // start pulse; first valid word two edges later
    rst = 0; start = 1; rst2 = 0; start2 = 1;
    cyc();
    chk("no valid yet", {31'h0, valid_out}, 32'h0);
    start = 0; start2 = 0;
    cyc();
    chk("first instr", instr_out, 32'h0);
    chk("first valid", {31'h0, valid_out}, 32'h1);
    chk("wrap pc_out", pc_out2, 32'hFFFF_FFFC);
    chk("wrap pc_plus4", pc_plus4_2, 32'h0);
    cyc();
    chk("second instr", instr_out, 32'h11);
    chk("wrap pc_out next", pc_out2, 32'h0);
    cyc();
    chk("third instr", instr_out, 32'h22);
    chk("third pc_out", pc_out, 32'h8);
    chk("count 3", {16'h0, fetch_count}, 32'd3);
    cyc();

    // stall three cycles at pc 0x10
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall addr", {22'h0, imem_addr}, 32'h4);
      chk("stall instr", instr_out, 32'h33);
      chk("stall count", {16'h0, fetch_count}, 32'd4);
    end
    stall = 0;
    cyc();
    chk("release instr", instr_out, 32'h44);
    chk("release pc_out", pc_out, 32'h10);
    chk("sat count", {29'h0, fetch_count2}, 32'd7);

    // redirect beats stall, misaligned target
    redirect_valid = 1; redirect_pc = 32'h103; stall = 1;
    cyc();
    redirect_valid = 0; stall = 0;
    chk("redir addr", {22'h0, imem_addr}, 32'h40);
    chk("redir valid", {31'h0, valid_out}, 32'h0);
    chk("redir instr", instr_out, 32'h0);
    cyc();
    chk("redir pc_out", pc_out, 32'h100);
    chk("redir fetched", instr_out, 32'h440);

    // HALT at 0x20
    redirect_valid = 1; redirect_pc = 32'h20;
    cyc();
    redirect_valid = 0;
    cyc();
    chk("halt instr", instr_out, 32'hFC00_0000);
    chk("halted", {31'h0, halted}, 32'h1);
    cyc();
    chk("halt drain", {31'h0, valid_out}, 32'h0);
    start = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("halt pc", {22'h0, imem_addr}, 32'h8);
    end
    start = 0;
    redirect_valid = 1; redirect_pc = 32'h40;
    cyc();
    redirect_valid = 0;
    chk("unhalt", {31'h0, halted}, 32'h0);
    cyc();
    chk("post halt fetch", instr_out, 32'h110);
    chk("sat hold", {29'h0, fetch_count2}, 32'd7);

    // reset while halted and stalled
    redirect_valid = 1; redirect_pc = 32'h20;
    cyc();
    redirect_valid = 0;
    cyc();
    stall = 1;
    cyc();
    rst = 1;
    cyc();
    rst = 0; stall = 0;
    chk("rst halted", {31'h0, halted}, 32'h0);
    chk("rst count", {16'h0, fetch_count}, 32'h0);
    chk("rst pc_out", pc_out, 32'h0);
    cyc();
    cyc();
    chk("idle no valid", {31'h0, valid_out}, 32'h0);

    // randomized phase
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? {6'h3F, 26'($urandom())} : $urandom();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 4095));
      cyc();
    end
    rst = 0; start = 0; stall = 0; redirect_valid = 0;
    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
